multicycle_control_32: RTL and testbench

Multi-cycle successor to the single-cycle main decoder. A Moore FSM sequences each MIPS instruction through fetch, decode, execute, memory and writeback steps, so one ALU and one unified memory can be shared. Adds memory wait-state handshaking, optional ADDI/BNE support, an illegal-opcode trap and a retired-instruction counter. Sits between the instruction register and the multi-cycle datapath muxes and enables.

---
 rtl/multicycle_control_32_pkg.sv | 65 ++++++
 rtl/multicycle_control_32_outdec.sv | 80 ++++++++
 rtl/multicycle_control_32.sv | 129 ++++++++++++
 tb/tb_multicycle_control_32.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_32_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller:
// opcode constants, ALUOp / ALUSrcB / PCSource encodings, FSM state
// encodings and the packed control word produced by the output decoder.
package multicycle_control_32_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp to the ALU control block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUSrcB select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSource select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM state encodings; 14 and 15 are unused and recover to IDLE
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_BEQ    = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_32_outdec.sv
// multicycle_ctrl_outdec: combinational state-to-control-word decoder.
// Ports:
//   state   - current FSM state
//   mem_rdy - effective memory-ready (gates IRWrite/PCWrite in FETCH)
//   is_bne  - current opcode is BNE (selects inverted zero test in BEQ)
//   ctrl    - decoded datapath control word
module multicycle_ctrl_outdec
  import multicycle_control_32_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_rdy,
  input  logic       is_bne,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC+4 only commit once the instruction word is actually there
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_write  = mem_rdy;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.branch_ne     = is_bne;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_32.sv
// multicycle_control_32: Moore-style main controller for a multi-cycle MIPS
// datapath. Holds the state register, next-state logic and the retired
// instruction counter; control outputs come from multicycle_ctrl_outdec.
// Ports:
//   clk, rst_n        - clock (rising edge), async active-low reset
//   opcode, mem_ready - IR opcode field, memory access completion
//   PCWrite..PCSource - datapath enables and mux selects
//   illegal_op        - sticky trap flag (set while in TRAP)
//   retired           - completed-instruction count, wraps
//   state             - current FSM state for debug
module multicycle_control_32
  import multicycle_control_32_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int EXT_OPS  = 1,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                BranchNe,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic                illegal_op,
  output logic [CNT_W-1:0]    retired,
  output logic [3:0]          state
);

  localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
  localparam logic [OPCODE_W-1:0] OPC_LW    = OPCODE_W'(OP_LW);
  localparam logic [OPCODE_W-1:0] OPC_SW    = OPCODE_W'(OP_SW);
  localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);
  localparam logic [OPCODE_W-1:0] OPC_BNE   = OPCODE_W'(OP_BNE);
  localparam logic [OPCODE_W-1:0] OPC_ADDI  = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] OPC_J     = OPCODE_W'(OP_J);

  logic             ext_ok;
  logic             rdy;
  logic             is_bne;
  logic             retire;
  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl;

  assign ext_ok = (EXT_OPS != 0);
  assign rdy    = (MEM_WAIT != 0) ? mem_ready : 1'b1;
  assign is_bne = (opcode == OPC_BNE);

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OPC_LW || opcode == OPC_SW) state_d = S_MEMADR;
        else if (opcode == OPC_RTYPE)             state_d = S_EXEC;
        else if (opcode == OPC_BEQ)               state_d = S_BEQ;
        else if (ext_ok && opcode == OPC_BNE)     state_d = S_BEQ;
        else if (ext_ok && opcode == OPC_ADDI)    state_d = S_ADDIEX;
        else if (opcode == OPC_J)                 state_d = S_JUMP;
        else                                      state_d = S_TRAP;
      end
      S_MEMADR: state_d = (opcode == OPC_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  // A store retires on its completing cycle; all other final states retire
  // unconditionally on the edge that leaves them.
  assign retire = (state_q inside {S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP}) ||
                  (state_q == S_MEMWR && rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  multicycle_ctrl_outdec u_outdec (
    .state   (state_q),
    .mem_rdy (rdy),
    .is_bne  (is_bne),
    .ctrl    (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign BranchNe    = ctrl.branch_ne;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ALUOP_W'(ctrl.alu_op);
  assign PCSource    = ctrl.pc_source;
  assign illegal_op  = ctrl.illegal;
  assign retired     = retired_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_32.sv
// Directed bench for multicycle_control_32: a default instance (A) and one
// with EXT_OPS=0, CNT_W=4, MEM_WAIT=0 (B).
module tb_multicycle_control_32;

  localparam logic [3:0] I = 4'd0,  F = 4'd1,  D = 4'd2,  MA = 4'd3,  MR = 4'd4;
  localparam logic [3:0] MWB = 4'd5, MW = 4'd6, EX = 4'd7, AWB = 4'd8, AE = 4'd9;
  localparam logic [3:0] AIW = 4'd10, BQ = 4'd11, JP = 4'd12, TR = 4'd13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A
  logic       rst_a, rdy_a;
  logic [5:0] op_a;
  logic       pcw_a, pcwc_a, bn_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, sa_a, ill_a;
  logic [1:0] sb_a, aop_a, ps_a;
  logic [31:0] ret_a;
  logic [3:0] st_a;
  logic [17:0] cw_a;
  assign cw_a = {pcw_a, pcwc_a, bn_a, iord_a, mr_a, mw_a, irw_a, m2r_a, rd_a, rw_a, sa_a,
                 sb_a, aop_a, ps_a, ill_a};

  multicycle_control_32 dut_a (
    .clk(clk), .rst_n(rst_a), .opcode(op_a), .mem_ready(rdy_a),
    .PCWrite(pcw_a), .PCWriteCond(pcwc_a), .BranchNe(bn_a), .IorD(iord_a),
    .MemRead(mr_a), .MemWrite(mw_a), .IRWrite(irw_a), .MemtoReg(m2r_a),
    .RegDst(rd_a), .RegWrite(rw_a), .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ALUOp(aop_a),
    .PCSource(ps_a), .illegal_op(ill_a), .retired(ret_a), .state(st_a)
  );

  // instance B
  logic       rst_b, rdy_b;
  logic [5:0] op_b;
  logic       pcw_b, pcwc_b, bn_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, sa_b, ill_b;
  logic [1:0] sb_b, aop_b, ps_b;
  logic [3:0] ret_b;
  logic [3:0] st_b;
  logic [17:0] cw_b;
  assign cw_b = {pcw_b, pcwc_b, bn_b, iord_b, mr_b, mw_b, irw_b, m2r_b, rd_b, rw_b, sa_b,
                 sb_b, aop_b, ps_b, ill_b};

  multicycle_control_32 #(.EXT_OPS(0), .CNT_W(4), .MEM_WAIT(0)) dut_b (
    .clk(clk), .rst_n(rst_b), .opcode(op_b), .mem_ready(rdy_b),
    .PCWrite(pcw_b), .PCWriteCond(pcwc_b), .BranchNe(bn_b), .IorD(iord_b),
    .MemRead(mr_b), .MemWrite(mw_b), .IRWrite(irw_b), .MemtoReg(m2r_b),
    .RegDst(rd_b), .RegWrite(rw_b), .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ALUOp(aop_b),
    .PCSource(ps_b), .illegal_op(ill_b), .retired(ret_b), .state(st_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected control word, written from the state table
  function automatic logic [17:0] exp_cw(input logic [3:0] st, input logic rdy, input logic bne);
    logic pcw, pcwc, bn, iord, mr, mw, irw, m2r, rd, rw, sa, ill;
    logic [1:0] sb, aop, ps;
    {pcw, pcwc, bn, iord, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      F:   begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
      D:   sb = 2'b11;
      MA:  begin sa = 1'b1; sb = 2'b10; end
      MR:  begin mr = 1'b1; iord = 1'b1; end
      MWB: begin rw = 1'b1; m2r = 1'b1; end
      MW:  begin mw = 1'b1; iord = 1'b1; end
      EX:  begin sa = 1'b1; aop = 2'b10; end
      AWB: begin rw = 1'b1; rd = 1'b1; end
      AE:  begin sa = 1'b1; sb = 2'b10; end
      AIW: rw = 1'b1;
      BQ:  begin sa = 1'b1; aop = 2'b01; pcwc = 1'b1; ps = 2'b01; bn = bne; end
      JP:  begin pcw = 1'b1; ps = 2'b10; end
      TR:  ill = 1'b1;
      default: ;
    endcase
    return {pcw, pcwc, bn, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, ill};
  endfunction

  // One clock: drive mem_ready at the falling edge, then check state and controls
  task automatic cyc(input bit b, input logic rdy, input logic [3:0] es, input logic bne,
                     input string nm);
    @(negedge clk);
    if (b) rdy_b = rdy; else rdy_a = rdy;
    #1;
    chk({nm, ".state"}, 32'(b ? st_b : st_a), 32'(es));
    // B ignores mem_ready, so its FETCH always behaves as ready
    chk({nm, ".ctrl"}, 32'(b ? cw_b : cw_a), 32'(exp_cw(es, b ? 1'b1 : rdy, bne)));
  endtask

  typedef struct packed {
    logic [5:0]  op;
    logic [2:0]  len;
    logic [23:0] seq;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{op: 6'b100011, len: 3'd5, seq: {F, D, MA, MR, MWB, I}};
    tbl[1] = '{op: 6'b101011, len: 3'd4, seq: {F, D, MA, MW, I, I}};
    tbl[2] = '{op: 6'b000000, len: 3'd4, seq: {F, D, EX, AWB, I, I}};
    tbl[3] = '{op: 6'b001000, len: 3'd4, seq: {F, D, AE, AIW, I, I}};
    tbl[4] = '{op: 6'b000100, len: 3'd3, seq: {F, D, BQ, I, I, I}};
    tbl[5] = '{op: 6'b000101, len: 3'd3, seq: {F, D, BQ, I, I, I}};
    tbl[6] = '{op: 6'b000010, len: 3'd3, seq: {F, D, JP, I, I, I}};

    rst_a = 1'b0; rdy_a = 1'b1; op_a = 6'b100011;
    rst_b = 1'b0; rdy_b = 1'b0; op_b = 6'b000101;

    // reset state
    #12;
    chk("a.rst.state", 32'(st_a), 32'(I));
    chk("a.rst.ctrl", 32'(cw_a), 32'd0);
    chk("a.rst.retired", ret_a, 32'd0);
    chk("b.rst.ctrl", 32'(cw_b), 32'd0);

    @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("a.idle.state", 32'(st_a), 32'(I));

    // table: one of each instruction, zero wait states
    for (int i = 0; i < 7; i++) begin
      op_a = tbl[i].op;
      for (int k = 0; k < int'(tbl[i].len); k++) begin
        cyc(1'b0, 1'b1, tbl[i].seq[23-4*k -: 4], tbl[i].op == 6'b000101,
            $sformatf("vec%0d.%0d", i, k));
        if (k == 0) chk($sformatf("vec%0d.retired", i), ret_a, 32'(i));
      end
    end

    // sw with three wait cycles in MEMWR
    op_a = 6'b101011;
    cyc(1'b0, 1'b1, F, 1'b0, "sw.f");
    chk("sw.retired0", ret_a, 32'd7);
    cyc(1'b0, 1'b1, D, 1'b0, "sw.d");
    cyc(1'b0, 1'b1, MA, 1'b0, "sw.ma");
    for (int w = 0; w < 3; w++) cyc(1'b0, 1'b0, MW, 1'b0, $sformatf("sw.wait%0d", w));
    cyc(1'b0, 1'b1, MW, 1'b0, "sw.done");
    chk("sw.retired_hold", ret_a, 32'd7);

    // R-type then j, each with two fetch wait cycles
    op_a = 6'b000000;
    cyc(1'b0, 1'b0, F, 1'b0, "r.fw0");
    chk("r.retired0", ret_a, 32'd8);
    cyc(1'b0, 1'b0, F, 1'b0, "r.fw1");
    cyc(1'b0, 1'b1, F, 1'b0, "r.f");
    cyc(1'b0, 1'b1, D, 1'b0, "r.d");
    cyc(1'b0, 1'b1, EX, 1'b0, "r.ex");
    cyc(1'b0, 1'b1, AWB, 1'b0, "r.wb");
    op_a = 6'b000010;
    cyc(1'b0, 1'b0, F, 1'b0, "j.fw0");
    chk("j.retired0", ret_a, 32'd9);
    cyc(1'b0, 1'b0, F, 1'b0, "j.fw1");
    cyc(1'b0, 1'b1, F, 1'b0, "j.f");
    cyc(1'b0, 1'b1, D, 1'b0, "j.d");
    cyc(1'b0, 1'b1, JP, 1'b0, "j.jump");

    // lw aborted by reset while waiting in MEMRD
    op_a = 6'b100011;
    cyc(1'b0, 1'b1, F, 1'b0, "abort.f");
    chk("abort.retired0", ret_a, 32'd10);
    cyc(1'b0, 1'b1, D, 1'b0, "abort.d");
    cyc(1'b0, 1'b1, MA, 1'b0, "abort.ma");
    cyc(1'b0, 1'b0, MR, 1'b0, "abort.mr0");
    cyc(1'b0, 1'b0, MR, 1'b0, "abort.mr1");
    rst_a = 1'b0;
    #1;
    chk("abort.state", 32'(st_a), 32'(I));
    chk("abort.ctrl", 32'(cw_a), 32'd0);
    chk("abort.retired", ret_a, 32'd0);
    @(negedge clk);
    rst_a = 1'b1;
    op_a = 6'b001000;
    #1;
    chk("addi.idle", 32'(st_a), 32'(I));
    cyc(1'b0, 1'b1, F, 1'b0, "addi.f");
    cyc(1'b0, 1'b1, D, 1'b0, "addi.d");
    cyc(1'b0, 1'b1, AE, 1'b0, "addi.ex");
    cyc(1'b0, 1'b1, AIW, 1'b0, "addi.wb");
    cyc(1'b0, 1'b1, F, 1'b0, "addi.next");
    chk("addi.retired", ret_a, 32'd1);

    // B: bne is illegal without EXT_OPS; mem_ready held low but ignored
    @(negedge clk);
    rst_b = 1'b1;
    cyc(1'b1, 1'b0, F, 1'b0, "b.bne.f");
    cyc(1'b1, 1'b0, D, 1'b0, "b.bne.d");
    for (int t = 0; t < 10; t++) begin
      cyc(1'b1, 1'b0, TR, 1'b0, $sformatf("b.trap%0d", t));
      chk($sformatf("b.trap%0d.ill", t), 32'(ill_b), 32'd1);
      chk($sformatf("b.trap%0d.retired", t), 32'(ret_b), 32'd0);
    end
    rst_b = 1'b0;
    #1;
    chk("b.trap.reset_ill", 32'(ill_b), 32'd0);
    chk("b.trap.reset_state", 32'(st_b), 32'(I));

    // B: 17 back-to-back beq, 4-bit counter wraps
    @(negedge clk);
    rst_b = 1'b1;
    op_b = 6'b000100;
    for (int n = 0; n < 17; n++) begin
      cyc(1'b1, 1'b0, F, 1'b0, $sformatf("b.beq%0d.f", n));
      chk($sformatf("b.beq%0d.retired", n), 32'(ret_b), 32'(n % 16));
      cyc(1'b1, 1'b0, D, 1'b0, $sformatf("b.beq%0d.d", n));
      cyc(1'b1, 1'b0, BQ, 1'b0, $sformatf("b.beq%0d.br", n));
    end
    cyc(1'b1, 1'b0, F, 1'b0, "b.wrap.f");
    chk("b.wrap.retired", 32'(ret_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
